// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and data memory.
// The unit is the master; the memory (or a bench model) is the slave.
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack data-memory access per instruction,
// with store lane formation, load alignment/extension and a pipeline stall.
module mem_access_unit (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     MEM_valid,
    input  logic [31:0]              MEM_signals,
    input  logic [31:0]              MEM_ALUout,
    input  logic [31:0]              MEM_RD2,
    mem_access_unit_if.master        dm,
    output logic                     mem_stall,
    output logic                     mem_done,
    output logic [31:0]              MEM_rdata,
    output logic                     mem_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic [2:0] {
        WID_B  = 3'b000,
        WID_H  = 3'b001,
        WID_W  = 3'b010,
        WID_BU = 3'b100,
        WID_HU = 3'b101
    } width_e;

    state_e      r_state;
    state_e      w_next;

    logic        r_req;
    logic        r_we;
    logic [29:0] r_addr;
    logic [1:0]  r_off;
    logic [2:0]  r_width;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_done;

    logic        w_rd;
    logic        w_wr;
    logic [2:0]  w_width;
    logic [1:0]  w_off;
    logic        w_illegal;
    logic        w_start;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_shifted;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_unused;

    assign w_rd     = MEM_signals[0];
    assign w_wr     = MEM_signals[1];
    assign w_width  = MEM_signals[4:2];
    assign w_off    = MEM_ALUout[1:0];
    assign w_unused = &{1'b0, MEM_signals[31:5]};

    // Legality is judged only for memory ops; plain ALU instructions never raise mem_err.
    always_comb begin
        w_illegal = 1'b0;
        if (w_rd && w_wr)
            w_illegal = 1'b1;
        case (w_width)
            WID_B:  ;
            WID_H:  if (w_off[0]) w_illegal = 1'b1;
            WID_W:  if (w_off != 2'b00) w_illegal = 1'b1;
            WID_BU: if (w_wr) w_illegal = 1'b1;
            WID_HU: if (w_wr || w_off[0]) w_illegal = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_wdata = MEM_RD2;
        w_wstrb = 4'b0000;
        if (w_wr) begin
            case (w_width)
                WID_B: begin
                    w_wdata = {4{MEM_RD2[7:0]}};
                    w_wstrb = 4'b0001 << w_off;
                end
                WID_H: begin
                    w_wdata = {2{MEM_RD2[15:0]}};
                    w_wstrb = w_off[1] ? 4'b1100 : 4'b0011;
                end
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    assign w_shifted = dm.dm_rdata >> {r_off, 3'b000};
    assign w_half    = r_off[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];

    always_comb begin
        case (r_width)
            WID_B:   w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            WID_BU:  w_load = {24'h000000, w_shifted[7:0]};
            WID_H:   w_load = {{16{w_half[15]}}, w_half};
            WID_HU:  w_load = {16'h0000, w_half};
            default: w_load = dm.dm_rdata;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        mem_err   = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            IDLE: begin
                mem_err = MEM_valid && (w_rd || w_wr) && w_illegal;
                w_start = MEM_valid && (w_rd || w_wr) && !w_illegal;
                if (w_start) begin
                    mem_stall = 1'b1;
                    w_next    = ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (dm.dm_ack)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_off   <= '0;
            r_width <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= w_wr;
                        r_addr  <= MEM_ALUout[31:2];
                        r_off   <= w_off;
                        r_width <= w_width;
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                    end
                end
                ACCESS: begin
                    if (dm.dm_ack) begin
                        r_req  <= 1'b0;
                        r_done <= 1'b1;
                        if (!r_we)
                            r_rdata <= w_load;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm.dm_req   = r_req;
    assign dm.dm_we    = r_we;
    assign dm.dm_addr  = {r_addr, 2'b00};
    assign dm.dm_wdata = r_wdata;
    assign dm.dm_wstrb = r_wstrb;
    assign mem_done    = r_done;
    assign MEM_rdata   = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench plays data memory and drives
// ack/rdata cycle by cycle; expected values are hand-computed constants.
module tb_mem_access_unit;

    logic        Clk;
    logic        Rst_n;
    logic        MEM_valid;
    logic [31:0] MEM_signals;
    logic [31:0] MEM_ALUout;
    logic [31:0] MEM_RD2;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] MEM_rdata;
    logic        mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit_if dm_bus ();

    mem_access_unit u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .MEM_valid   (MEM_valid),
        .MEM_signals (MEM_signals),
        .MEM_ALUout  (MEM_ALUout),
        .MEM_RD2     (MEM_RD2),
        .dm          (dm_bus.master),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .MEM_rdata   (MEM_rdata),
        .mem_err     (mem_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Control words: bit0 read, bit1 write, bits[4:2] width.
    localparam logic [31:0] SIG_LB  = 32'h01;
    localparam logic [31:0] SIG_LH  = 32'h05;
    localparam logic [31:0] SIG_LW  = 32'h09;
    localparam logic [31:0] SIG_LBU = 32'h11;
    localparam logic [31:0] SIG_LHU = 32'h15;
    localparam logic [31:0] SIG_SB  = 32'h02;
    localparam logic [31:0] SIG_SH  = 32'h06;
    localparam logic [31:0] SIG_RSV = 32'h0D;
    localparam logic [31:0] SIG_RW  = 32'h0B;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] sig, input logic [31:0] addr,
                         input logic [31:0] wd);
        MEM_valid   = v;
        MEM_signals = sig;
        MEM_ALUout  = addr;
        MEM_RD2     = wd;
    endtask

    // Zero-wait load: T0 issue, T1 ack, T2 DONE; checks result at T2.
    task automatic zero_wait_load(input string tag, input logic [31:0] sig,
                                  input logic [31:0] addr, input logic [31:0] word,
                                  input logic [31:0] exp);
        tick();
        drive(1'b1, sig, addr, 32'h0);
        sample();
        check({tag, "_t0_stall"}, {31'b0, mem_stall}, 32'd1);
        tick();
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = word;
        sample();
        check({tag, "_t1_req"}, {31'b0, dm_bus.dm_req}, 32'd1);
        tick();
        dm_bus.dm_ack = 1'b0;
        sample();
        check({tag, "_done"}, {31'b0, mem_done}, 32'd1);
        check({tag, "_rdata"}, MEM_rdata, exp);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic err_case(input string tag, input logic [31:0] sig, input logic [31:0] addr);
        tick();
        drive(1'b1, sig, addr, 32'h1234_5678);
        sample();
        check({tag, "_err"},   {31'b0, mem_err},   32'd1);
        check({tag, "_stall"}, {31'b0, mem_stall}, 32'd0);
        tick();
        sample();
        check({tag, "_req"},   {31'b0, dm_bus.dm_req}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        Rst_n           = 1'b0;
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) tick();
        sample();
        check("rst_req",   {31'b0, dm_bus.dm_req}, 32'd0);
        check("rst_done",  {31'b0, mem_done},      32'd0);
        check("rst_rdata", MEM_rdata,              32'd0);
        check("rst_addr",  dm_bus.dm_addr,         32'd0);
        check("rst_wstrb", {28'b0, dm_bus.dm_wstrb}, 32'd0);
        check("rst_stall", {31'b0, mem_stall},     32'd0);
        tick();
        Rst_n = 1'b1;

        // LW @0x100, ack at T1 with 0xDEADBEEF.
        tick();
        drive(1'b1, SIG_LW, 32'h100, 32'h0);
        sample();
        check("lw_t0_stall", {31'b0, mem_stall},     32'd1);
        check("lw_t0_req",   {31'b0, dm_bus.dm_req}, 32'd0);
        tick();
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'hDEAD_BEEF;
        sample();
        check("lw_t1_req",   {31'b0, dm_bus.dm_req},   32'd1);
        check("lw_t1_addr",  dm_bus.dm_addr,           32'h100);
        check("lw_t1_wstrb", {28'b0, dm_bus.dm_wstrb}, 32'h0);
        check("lw_t1_we",    {31'b0, dm_bus.dm_we},    32'd0);
        check("lw_t1_stall", {31'b0, mem_stall},       32'd1);
        tick();
        dm_bus.dm_ack = 1'b0;
        sample();
        check("lw_t2_done",  {31'b0, mem_done},      32'd1);
        check("lw_t2_rdata", MEM_rdata,              32'hDEAD_BEEF);
        check("lw_t2_stall", {31'b0, mem_stall},     32'd0);
        check("lw_t2_req",   {31'b0, dm_bus.dm_req}, 32'd0);

        // ADD straight after the load's DONE.
        tick();
        drive(1'b1, 32'h0, 32'h0000_0104, 32'h0);
        sample();
        check("add_stall", {31'b0, mem_stall},     32'd0);
        check("add_err",   {31'b0, mem_err},       32'd0);
        check("add_done",  {31'b0, mem_done},      32'd0);
        check("add_rdata", MEM_rdata,              32'hDEAD_BEEF);
        tick();
        sample();
        check("add_req",   {31'b0, dm_bus.dm_req}, 32'd0);

        // SB @0x103 data 0xA5, four wait cycles before ack.
        tick();
        drive(1'b1, SIG_SB, 32'h103, 32'h0000_00A5);
        sample();
        check("sb_t0_stall", {31'b0, mem_stall}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            check("sb_wait_req",   {31'b0, dm_bus.dm_req}, 32'd1);
            check("sb_wait_stall", {31'b0, mem_stall},     32'd1);
        end
        check("sb_wdata", dm_bus.dm_wdata,           32'hA5A5_A5A5);
        check("sb_wstrb", {28'b0, dm_bus.dm_wstrb},  32'b1000);
        check("sb_we",    {31'b0, dm_bus.dm_we},     32'd1);
        check("sb_addr",  dm_bus.dm_addr,            32'h100);
        tick();
        dm_bus.dm_ack = 1'b1;
        sample();
        check("sb_ack_stall", {31'b0, mem_stall}, 32'd1);
        tick();
        dm_bus.dm_ack = 1'b0;
        sample();
        check("sb_done",  {31'b0, mem_done},  32'd1);
        check("sb_stall", {31'b0, mem_stall}, 32'd0);
        check("sb_rdata_kept", MEM_rdata, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // Load extraction from 0x80FF7F01.
        zero_wait_load("lb",  SIG_LB,  32'h102, 32'h80FF_7F01, 32'hFFFF_FFFF);
        zero_wait_load("lbu", SIG_LBU, 32'h103, 32'h80FF_7F01, 32'h0000_0080);
        zero_wait_load("lh",  SIG_LH,  32'h100, 32'h80FF_7F01, 32'h0000_7F01);
        zero_wait_load("lhu", SIG_LHU, 32'h102, 32'h80FF_7F01, 32'h0000_80FF);

        // SH @0x102 lane formation.
        tick();
        drive(1'b1, SIG_SH, 32'h102, 32'hCAFE_1234);
        tick();
        sample();
        check("sh_wdata", dm_bus.dm_wdata,          32'h1234_1234);
        check("sh_wstrb", {28'b0, dm_bus.dm_wstrb}, 32'b1100);
        dm_bus.dm_ack = 1'b1;
        tick();
        dm_bus.dm_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        err_case("e_lw_mis",  SIG_LW,  32'h102);
        err_case("e_sh_mis",  SIG_SH,  32'h001);
        err_case("e_rsv",     SIG_RSV, 32'h100);
        err_case("e_rw",      SIG_RW,  32'h100);

        // Reset while in ACCESS, then a stray ack.
        tick();
        drive(1'b1, SIG_LW, 32'h200, 32'h0);
        tick();
        sample();
        check("rsta_req_before", {31'b0, dm_bus.dm_req}, 32'd1);
        Rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        sample();
        check("rsta_req_after",   {31'b0, dm_bus.dm_req}, 32'd0);
        check("rsta_stall_after", {31'b0, mem_stall},     32'd0);
        Rst_n = 1'b1;
        tick();
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'h5555_5555;
        tick();
        dm_bus.dm_ack = 1'b0;
        sample();
        check("rsta_no_done",  {31'b0, mem_done}, 32'd0);
        check("rsta_rdata",    MEM_rdata,         32'd0);
        tick();
        sample();
        check("rsta_no_done2", {31'b0, mem_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine downstream of the EX/MEM pipeline register. Decodes the MEM-stage control word, performs one data-memory access per instruction over a req/ack handshake, and stalls the pipeline until the access completes. Also aligns and extends load data and generates byte strobes for stores. Its result feeds the MEM/WB register; `mem_stall` freezes PC, IF/ID, ID/EX and EX/MEM.

## Interface
Parameters: none. All datapaths are 32 bits; the data memory is word-addressed with byte strobes.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  synchronous, active-low reset.
- `MEM_valid`  in  1  MEM-stage instruction is not a bubble.
- `MEM_signals`  in  32  control word:
  - bit0 MemRead.
  - bit1 MemWrite.
  - bits[4:2] width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - other bits ignored.
- `MEM_ALUout`  in  32  effective byte address.
- `MEM_RD2`  in  32  store data.
- `dm_req`  out  1  access request.
- `dm_we`  out  1  1 = write.
- `dm_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_wstrb`  out  4  byte enables; 0000 on reads.
- `dm_ack`  in  1  access complete; `dm_rdata` is valid in the same cycle.
- `dm_rdata`  in  32  read word.
- `mem_stall`  out  1  hold upstream stages.
- `mem_done`  out  1  one-cycle pulse: access finished.
- `MEM_rdata`  out  32  aligned, extended load result.
- `mem_err`  out  1  misaligned or illegal access; no access is issued.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- `start` = `MEM_valid & (MemRead | MemWrite) & ~mem_err`.
- `mem_err` is combinational and asserted only in IDLE. It is 1 when `MEM_valid` and any of:
  - MemRead and MemWrite are both set;
  - the width code is reserved (011, 110, 111);
  - a store uses BU or HU;
  - H/HU with `addr[0]`=1;
  - W with `addr[1:0]`≠00.
- On `mem_err` the instruction passes with no stall and no request; the trap logic handles it.
- IDLE:
  - `start` drives `mem_stall`=1 combinationally.
  - Latch address, `we`, width, `wdata` and `wstrb`; go to ACCESS.
  - Otherwise stay in IDLE with stall 0.
- ACCESS:
  - `dm_req`=1; all `dm_*` outputs come from latched registers and stay stable until ack.
  - `mem_stall`=1.
  - On `dm_ack`: capture the extracted load data into `MEM_rdata` (stores leave it unchanged) and go to DONE.
- DONE:
  - `mem_done`=1, `mem_stall`=0, `dm_req`=0.
  - Inputs are ignored, so the same instruction cannot retrigger while EX/MEM advances at this edge.
  - Next state is IDLE.
- Store lane formation:
  - B: `wdata` = byte replicated ×4; `wstrb` = `1<<addr[1:0]`.
  - H: `wdata` = half replicated ×2; `wstrb` = 0011 if `addr[1]`=0, else 1100.
  - W: `wstrb` = 1111.
- Load extraction:
  - B/BU select byte `addr[1:0]`; H/HU select half `addr[1]`.
  - B and H sign-extend to 32 bits; BU and HU zero-extend.

## Timing
- Reset (`Rst_n`=0 at an edge): state becomes IDLE; every output register (`dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_wstrb`, `MEM_rdata`, `mem_done`) goes to 0.
- Reset during ACCESS: `dm_req` drops after that edge, and any later `dm_ack` is ignored.
- `dm_ack` is sampled only in ACCESS; it is ignored in IDLE and DONE.
- Latency:
  - Instruction arrives at cycle T0 (stall=1).
  - `dm_req` is high from T1.
  - With ack at Tk (k≥1), DONE occurs at Tk+1 and EX/MEM advances at the end of Tk+1.
  - Minimum occupancy is 3 cycles (zero-wait memory acks at T1).
- `dm_req` deasserts the cycle after ack; back-to-back requests are separated by at least DONE plus a new T0.
- `mem_stall` is never high in DONE, and never high in IDLE without `start`.
- Non-memory instructions and bubbles: zero added latency, all `dm_*` outputs idle.

## Test plan
- Reset, then LW at 0x100 with ack at T1 returning 0xDEADBEEF:
  - `dm_addr`=0x100, `dm_wstrb`=0000, stall high for T0–T1;
  - `mem_done` and `MEM_rdata`=0xDEADBEEF at T2.
- SB at 0x103 with data 0x000000A5:
  - `dm_wdata`=0xA5A5A5A5, `dm_wstrb`=1000, `dm_we`=1;
  - with ack after 4 wait cycles, stall stays high until ack, then DONE.
- `dm_rdata`=0x80FF7F01:
  - LB @0x102 → 0xFFFFFFFF; LBU @0x103 → 0x00000080; LH @0x100 → 0x00007F01; LHU @0x102 → 0x000080FF.
- Error cases: LW @0x102, SH @0x001, width code 011, and Read+Write together each give `mem_err`=1, `dm_req`=0, stall 0.
- `Rst_n` low during ACCESS: state returns to IDLE and `dm_req`=0 next cycle; an ack pulse afterwards produces no `mem_done`.
- An ADD (MEM_signals bits[1:0]=00) immediately after a load's DONE: no stall, no request; the load result is unaffected.
